// File: rtl/bus_arbiter_4.sv
// Round-robin arbiter: four masters share one slave port.
// A grant is held until the slave acks or the timeout expires. At least one
// IDLE cycle separates consecutive grants.
module bus_arbiter_4 #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] m_req,
  input  logic       s_ack,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       s_valid,
  output logic [3:0] m_done,
  output logic [3:0] m_err
);

  // TIMEOUT == 0 means the abort path is never taken.
  localparam bit               TO_EN   = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q, state_d;
  logic [3:0]       gnt_d, done_d, err_d;
  logic [1:0]       sel_d, ptr_q, ptr_d;
  logic             vld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             found;
  logic [1:0]       pick, idx;

  // Round-robin search: ptr+1, ptr+2, ptr+3, then ptr itself.
  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    idx   = '0;
    for (int k = 1; k <= 4; k++) begin
      idx = ptr_q + k[1:0];
      if (!found && m_req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // Next-state and next-output logic; all outputs leave through registers.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt;
    sel_d   = sel;
    vld_d   = s_valid;
    done_d  = '0;
    err_d   = '0;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        gnt_d = '0;
        vld_d = 1'b0;
        if (found) begin
          state_d = BUSY;
          gnt_d   = 4'b0001 << pick;
          sel_d   = pick;
          vld_d   = 1'b1;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        // Ack takes precedence over a timeout landing in the same cycle.
        if (s_ack) begin
          state_d     = IDLE;
          gnt_d       = '0;
          vld_d       = 1'b0;
          done_d[sel] = 1'b1;
          ptr_d       = sel;
        end else if (TO_EN && cnt_q == TO_LAST) begin
          state_d    = IDLE;
          gnt_d      = '0;
          vld_d      = 1'b0;
          err_d[sel] = 1'b1;
          ptr_d      = sel;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      gnt     <= '0;
      sel     <= '0;
      s_valid <= 1'b0;
      m_done  <= '0;
      m_err   <= '0;
      cnt_q   <= '0;
      ptr_q   <= 2'd3;
    end else begin
      state_q <= state_d;
      gnt     <= gnt_d;
      sel     <= sel_d;
      s_valid <= vld_d;
      m_done  <= done_d;
      m_err   <= err_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule

// File: tb/tb_bus_arbiter_4.sv
// Directed bench for bus_arbiter_4 (TIMEOUT = 4).
module tb_bus_arbiter_4;

  logic       clk;
  logic       reset;
  logic [3:0] m_req;
  logic       s_ack;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       s_valid;
  logic [3:0] m_done;
  logic [3:0] m_err;

  int nvec = 0;
  int nerr = 0;

  bus_arbiter_4 #(.CNT_W(8), .TIMEOUT(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .m_req   (m_req),
    .s_ack   (s_ack),
    .gnt     (gnt),
    .sel     (sel),
    .s_valid (s_valid),
    .m_done  (m_done),
    .m_err   (m_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare all outputs at once against a hand-computed vector.
  task automatic chk(input string tag, input logic [3:0] g, input logic [1:0] s,
                     input logic v, input logic [3:0] d, input logic [3:0] e);
    logic [14:0] obs, exp;
    obs = {gnt, sel, s_valid, m_done, m_err};
    exp = {g, s, v, d, e};
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got gnt=%b sel=%0d vld=%b done=%b err=%b, want gnt=%b sel=%0d vld=%b done=%b err=%b",
             tag, gnt, sel, s_valid, m_done, m_err, g, s, v, d, e);
    end
  endtask

  initial begin
    reset = 1'b0;
    m_req = '0;
    s_ack = 1'b0;
    #2;
    chk("reset", 4'b0000, 2'd0, 1'b0, 4'b0000, 4'b0000);
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("idle_no_req", 4'b0000, 2'd0, 1'b0, 4'b0000, 4'b0000);

    // All four requesting, slave acks on the first BUSY cycle: 0,1,2,3,0.
    m_req = 4'b1111;
    s_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("rr_gnt%0d", i), 4'b0001 << (i % 4), 2'(i % 4), 1'b1, 4'b0000, 4'b0000);
      tick();
      chk($sformatf("rr_done%0d", i), 4'b0000, 2'(i % 4), 1'b0, 4'b0001 << (i % 4), 4'b0000);
    end
    m_req = '0;
    s_ack = 1'b0;
    tick();
    chk("rr_idle", 4'b0000, 2'd0, 1'b0, 4'b0000, 4'b0000);

    // Single request from master 2, ack one cycle after the grant.
    m_req = 4'b0100;
    tick();
    chk("m2_gnt", 4'b0100, 2'd2, 1'b1, 4'b0000, 4'b0000);
    m_req = '0;
    tick();
    chk("m2_busy2", 4'b0100, 2'd2, 1'b1, 4'b0000, 4'b0000);
    s_ack = 1'b1;
    tick();
    chk("m2_done", 4'b0000, 2'd2, 1'b0, 4'b0100, 4'b0000);
    s_ack = 1'b0;
    tick();
    chk("m2_idle", 4'b0000, 2'd2, 1'b0, 4'b0000, 4'b0000);

    // Master 1, never acked: four BUSY cycles then an error pulse.
    m_req = 4'b0010;
    tick();
    chk("to_busy1", 4'b0010, 2'd1, 1'b1, 4'b0000, 4'b0000);
    m_req = '0;
    for (int i = 2; i <= 4; i++) begin
      tick();
      chk($sformatf("to_busy%0d", i), 4'b0010, 2'd1, 1'b1, 4'b0000, 4'b0000);
    end
    tick();
    chk("to_err", 4'b0000, 2'd1, 1'b0, 4'b0000, 4'b0010);

    // ptr=1 now: with masters 0 and 3 requesting, 3 comes first.
    m_req = 4'b1001;
    tick();
    chk("to_next_rr", 4'b1000, 2'd3, 1'b1, 4'b0000, 4'b0000);

    // Master 3 drops its request, master 1 requests: grant stands.
    m_req = 4'b0010;
    tick();
    chk("hold_m3_a", 4'b1000, 2'd3, 1'b1, 4'b0000, 4'b0000);
    tick();
    chk("hold_m3_b", 4'b1000, 2'd3, 1'b1, 4'b0000, 4'b0000);
    s_ack = 1'b1;
    tick();
    chk("hold_m3_done", 4'b0000, 2'd3, 1'b0, 4'b1000, 4'b0000);
    s_ack = 1'b0;
    tick();
    chk("hold_m1_gnt", 4'b0010, 2'd1, 1'b1, 4'b0000, 4'b0000);

    // Ack on the 4th BUSY cycle coincides with the timeout: ack wins.
    m_req = '0;
    tick();
    chk("aw_busy2", 4'b0010, 2'd1, 1'b1, 4'b0000, 4'b0000);
    tick();
    chk("aw_busy3", 4'b0010, 2'd1, 1'b1, 4'b0000, 4'b0000);
    tick();
    chk("aw_busy4", 4'b0010, 2'd1, 1'b1, 4'b0000, 4'b0000);
    s_ack = 1'b1;
    tick();
    chk("aw_done", 4'b0000, 2'd1, 1'b0, 4'b0010, 4'b0000);
    s_ack = 1'b0;

    // Reset mid-BUSY with master 2 granted: clears without a clock edge.
    m_req = 4'b0100;
    tick();
    chk("rst_pre", 4'b0100, 2'd2, 1'b1, 4'b0000, 4'b0000);
    #2;
    reset = 1'b0;
    #1;
    chk("rst_async", 4'b0000, 2'd0, 1'b0, 4'b0000, 4'b0000);
    m_req = 4'b0101;
    tick();
    chk("rst_held", 4'b0000, 2'd0, 1'b0, 4'b0000, 4'b0000);
    reset = 1'b1;
    tick();
    chk("rst_m0_first", 4'b0001, 2'd0, 1'b1, 4'b0000, 4'b0000);
    m_req = '0;
    s_ack = 1'b1;
    tick();
    chk("rst_m0_done", 4'b0000, 2'd0, 1'b0, 4'b0001, 4'b0000);
    s_ack = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
